nfsr_keystream_ctrl: RTL

Sequencer for the 24-bit NFSR keystream register.
- Loads a seed, runs a fixed warm-up with output discarded, then collects serial output bits into OUT_W-bit words.
- Delivers the words over a valid/ready handshake.
- Sits between the NFSR instance (drives its Par_load/shift_en/SEED, reads its ser_out) and the downstream cipher/consumer.

---
 rtl/nfsr_keystream_ctrl.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/nfsr_keystream_ctrl.sv
// nfsr_keystream_ctrl: sequencer for an external NFSR keystream register.
// Loads a seed, discards WARMUP shifts, then packs serial output bits
// MSB-first into OUT_W-bit words delivered over a valid/ready handshake.
// The NFSR is frozen (shift_en low) while a word waits for the consumer.
// Optional build macro: NFSR_CTRL_ONES_CNT_EN adds a saturating ones_cnt
// output counting the 1 bits sampled during keystream generation.
module nfsr_keystream_ctrl #(
  parameter int WIDTH  = 24,
  parameter int WARMUP = 48,
  parameter int OUT_W  = 8
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] seed,
  input  logic [15:0]      num_words,
  output logic             busy,
  output logic             done,
  output logic             Par_load,
  output logic             shift_en,
  output logic [WIDTH-1:0] nfsr_seed,
  input  logic             nfsr_ser_out,
  output logic [OUT_W-1:0] ks_data,
  output logic             ks_valid,
  input  logic             ks_ready
`ifdef NFSR_CTRL_ONES_CNT_EN
  ,
  output logic [15:0]      ones_cnt
`endif
);

  localparam int WCW = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam int BCW = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_WARM = 3'd2,
    S_GEN  = 3'd3,
    S_OUT  = 3'd4
  } state_t;

  state_t           state_q, state_d;

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             par_load_q, par_load_d;
  logic             shift_en_q, shift_en_d;
  logic [WIDTH-1:0] seed_q, seed_d;
  logic [OUT_W-1:0] ks_data_q, ks_data_d;
  logic             ks_valid_q, ks_valid_d;
  logic [OUT_W-1:0] sr_q, sr_d;
  logic [WCW-1:0]   warm_cnt_q, warm_cnt_d;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [15:0]      remaining_q, remaining_d;
`ifdef NFSR_CTRL_ONES_CNT_EN
  logic [15:0]      ones_cnt_q, ones_cnt_d;
`endif

  // Session is accepted only from IDLE, without abort, and with work to do.
  logic start_acc;
  logic warm_last;
  logic bit_last;
  logic handshake;

  assign start_acc = (state_q == S_IDLE) && start && !abort && (num_words != 16'd0);
  assign warm_last = (32'(warm_cnt_q) == 32'(WARMUP - 1));
  assign bit_last  = (32'(bit_cnt_q) == 32'(OUT_W - 1));
  assign handshake = (state_q == S_OUT) && ks_valid_q && ks_ready;

  // State register.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_acc) state_d = S_LOAD;
          else           state_d = S_IDLE;
        end
        S_LOAD: begin
          if (WARMUP == 0) state_d = S_GEN;
          else             state_d = S_WARM;
        end
        S_WARM: begin
          if (warm_last) state_d = S_GEN;
          else           state_d = S_WARM;
        end
        S_GEN: begin
          if (bit_last) state_d = S_OUT;
          else          state_d = S_GEN;
        end
        S_OUT: begin
          if (handshake) begin
            if (remaining_q == 16'd1) state_d = S_IDLE;
            else                      state_d = S_GEN;
          end else begin
            state_d = S_OUT;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output and datapath next values; control outputs decode the next state
  // so the registered versions line up with the state they belong to.
  always_comb begin
    busy_d      = (state_d != S_IDLE);
    par_load_d  = (state_d == S_LOAD);
    shift_en_d  = (state_d == S_WARM) || (state_d == S_GEN);
    done_d      = 1'b0;
    seed_d      = seed_q;
    ks_data_d   = ks_data_q;
    ks_valid_d  = ks_valid_q;
    sr_d        = sr_q;
    warm_cnt_d  = '0;
    bit_cnt_d   = '0;
    remaining_d = remaining_q;
`ifdef NFSR_CTRL_ONES_CNT_EN
    ones_cnt_d  = ones_cnt_q;
`endif
    if (abort) begin
      ks_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_acc) begin
            seed_d      = seed;
            remaining_d = num_words;
`ifdef NFSR_CTRL_ONES_CNT_EN
            ones_cnt_d  = 16'd0;
`endif
          end else if (start) begin
            // Zero-length session: acknowledge immediately, never touch the NFSR.
            done_d = 1'b1;
          end else begin
            done_d = 1'b0;
          end
        end
        S_WARM: begin
          warm_cnt_d = warm_cnt_q + WCW'(1);
        end
        S_GEN: begin
          bit_cnt_d = bit_cnt_q + BCW'(1);
          sr_d      = (sr_q << 1) | OUT_W'(nfsr_ser_out);
`ifdef NFSR_CTRL_ONES_CNT_EN
          if (nfsr_ser_out && (ones_cnt_q != 16'hFFFF)) begin
            ones_cnt_d = ones_cnt_q + 16'd1;
          end else begin
            ones_cnt_d = ones_cnt_q;
          end
`endif
        end
        S_OUT: begin
          if (!ks_valid_q) begin
            // First OUT cycle: publish the collected word.
            ks_data_d  = sr_q;
            ks_valid_d = 1'b1;
          end else if (ks_ready) begin
            ks_valid_d  = 1'b0;
            remaining_d = remaining_q - 16'd1;
            if (remaining_q == 16'd1) done_d = 1'b1;
            else                      done_d = 1'b0;
          end else begin
            ks_valid_d = 1'b1;
          end
        end
        default: begin
          ks_valid_d = ks_valid_q;
        end
      endcase
    end
  end

  // Output and datapath registers.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      par_load_q  <= 1'b0;
      shift_en_q  <= 1'b0;
      seed_q      <= '0;
      ks_data_q   <= '0;
      ks_valid_q  <= 1'b0;
      sr_q        <= '0;
      warm_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      remaining_q <= 16'd0;
`ifdef NFSR_CTRL_ONES_CNT_EN
      ones_cnt_q  <= 16'd0;
`endif
    end else begin
      busy_q      <= busy_d;
      done_q      <= done_d;
      par_load_q  <= par_load_d;
      shift_en_q  <= shift_en_d;
      seed_q      <= seed_d;
      ks_data_q   <= ks_data_d;
      ks_valid_q  <= ks_valid_d;
      sr_q        <= sr_d;
      warm_cnt_q  <= warm_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      remaining_q <= remaining_d;
`ifdef NFSR_CTRL_ONES_CNT_EN
      ones_cnt_q  <= ones_cnt_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign Par_load  = par_load_q;
  assign shift_en  = shift_en_q;
  assign nfsr_seed = seed_q;
  assign ks_data   = ks_data_q;
  assign ks_valid  = ks_valid_q;
`ifdef NFSR_CTRL_ONES_CNT_EN
  assign ones_cnt  = ones_cnt_q;
`endif

endmodule
